// File: rtl/lab4_net_RouterPkg.sv
// Shared router definitions: input-port index constants and the output-controller FSM state type.
package lab4_net_RouterPkg;

    localparam int PORT_W = 0;
    localparam int PORT_T = 1;
    localparam int PORT_E = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/lab4_net_RoundRobinPicker.sv
// Combinational circular priority pick: lowest requester at or after the one-hot prio position.
module lab4_net_RoundRobinPicker #(
    parameter int p_num_reqs  = 3,
    parameter int c_sel_nbits = $clog2(p_num_reqs)
) (
    input  logic [p_num_reqs-1:0]  reqs,
    input  logic [p_num_reqs-1:0]  prio,
    output logic [c_sel_nbits-1:0] winner,
    output logic                   any_val
);

    // Larger offsets are visited first so the smallest circular distance wins.
    always_comb begin
        winner = '0;
        for (int k = p_num_reqs - 1; k >= 0; k--) begin
            for (int i = 0; i < p_num_reqs; i++) begin
                if (prio[i] && reqs[(i + k) % p_num_reqs]) begin
                    winner = c_sel_nbits'((i + k) % p_num_reqs);
                end
            end
        end
        any_val = |reqs;
    end

endmodule

// File: rtl/lab4_net_router_output_ctrl.sv
// Output-port arbiter: round-robin grant with a winner held stable under downstream backpressure.
module lab4_net_router_output_ctrl
    import lab4_net_RouterPkg::*;
#(
    parameter int p_num_reqs  = 3,
    parameter int c_sel_nbits = $clog2(p_num_reqs)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [p_num_reqs-1:0]  reqs,
    output logic [p_num_reqs-1:0]  grants,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [c_sel_nbits-1:0] sel
);

    state_t                   state;
    logic [p_num_reqs-1:0]    prio;
    logic [c_sel_nbits-1:0]   held;
    logic [c_sel_nbits-1:0]   winner;
    logic                     any_val;
    logic                     held_req;

    function automatic logic [p_num_reqs-1:0] onehot(input logic [c_sel_nbits-1:0] idx);
        logic [p_num_reqs-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // One-hot of (idx+1) mod p_num_reqs: the port just served drops to lowest priority.
    function automatic logic [p_num_reqs-1:0] next_prio(input logic [c_sel_nbits-1:0] idx);
        logic [p_num_reqs-1:0] oh;
        oh = onehot(idx);
        return {oh[p_num_reqs-2:0], oh[p_num_reqs-1]};
    endfunction

    lab4_net_RoundRobinPicker #(
        .p_num_reqs  (p_num_reqs),
        .c_sel_nbits (c_sel_nbits)
    ) u_picker (
        .reqs    (reqs),
        .prio    (prio),
        .winner  (winner),
        .any_val (any_val)
    );

    assign held_req = reqs[held];

    // Outputs are purely combinational; reset overrides them without waiting for a clock.
    always_comb begin
        out_val = 1'b0;
        grants  = '0;
        sel     = held;
        case (state)
            IDLE: begin
                if (any_val) begin
                    out_val = 1'b1;
                    sel     = winner;
                    if (out_rdy) grants = onehot(winner);
                end
            end
            HOLD: begin
                if (held_req) begin
                    out_val = 1'b1;
                    if (out_rdy) grants = onehot(held);
                end
            end
            default: ;
        endcase
        if (!reset) begin
            out_val = 1'b0;
            grants  = '0;
            sel     = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            prio  <= p_num_reqs'(1);
            held  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_val && out_rdy) begin
                        prio <= next_prio(winner);
                    end else if (any_val) begin
                        held  <= winner;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (held_req && out_rdy) begin
                        prio  <= next_prio(held);
                        state <= IDLE;
                    end else if (!held_req) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
